analyzer_capture_buffer: RTL

Parametrised capture engine for the logic analyzer, the next generation of the analyzer's wave datastore. It samples up to 32 digital channels at a programmable divided rate into a circular RAM, and keeps a programmable number of pre-trigger samples. Read-back is re-mapped so that logical address 0 is always the oldest sample. It sits between the trigger combiner (which drives `trig`) and the analyzer's AXI-style slave register/readout logic.

---
 rtl/analyzer_pkg.sv | 41 ++++
 rtl/analyzer_wave_ram.sv | 44 ++++
 rtl/analyzer_capture_buffer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/analyzer_pkg.sv
// Shared types for the logic analyzer capture path.
//   capture_state_t : capture engine state encoding
//   trig_mode_t     : global combine mode applied by the trigger combiner
//   trig_op_t       : per-channel trigger operation field
//   trig_field_t    : per-channel op/value pair as stored in trigger config
//   is_busy()       : true while a capture is writing the buffer
package analyzer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT,
        ST_POST,
        ST_DONE
    } capture_state_t;

    typedef enum logic [1:0] {
        TRIG_MODE_AND  = 2'd0,
        TRIG_MODE_OR   = 2'd1,
        TRIG_MODE_NAND = 2'd2,
        TRIG_MODE_NOR  = 2'd3
    } trig_mode_t;

    typedef enum logic [2:0] {
        TRIG_OP_IGNORE = 3'd0,
        TRIG_OP_LEVEL  = 3'd1,
        TRIG_OP_RISE   = 3'd2,
        TRIG_OP_FALL   = 3'd3,
        TRIG_OP_EDGE   = 3'd4
    } trig_op_t;

    typedef struct packed {
        trig_op_t op;
        logic     value;
    } trig_field_t;

    function automatic logic is_busy(input capture_state_t s);
        return (s == ST_PRE) || (s == ST_WAIT) || (s == ST_POST);
    endfunction

endpackage

// File: rtl/analyzer_wave_ram.sv
// Simple dual-port sample RAM, 2^ADDR_W x DATA_W.
//   clk, analyzer_rstn_sync : clock, async active-low reset (read register only)
//   wr_en_i/wr_addr_i/wr_data_i : synchronous write port
//   rd_en_i/rd_addr_i        : read request, data appears one cycle later
//   rd_data_o                : registered read data, holds when rd_en_i is low
module analyzer_wave_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              analyzer_rstn_sync,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // NOTE: the array has no reset so it maps onto block RAM; clearing it
    // would force a flop-based implementation. Non-blocking assignments keep
    // every clocked update race-free against other always_ff blocks.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge analyzer_rstn_sync) begin
        if (!analyzer_rstn_sync) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/analyzer_capture_buffer.sv
// Logic analyzer capture engine: samples digital_in at a divided rate into a
// circular RAM, keeps pretrig_len samples before the trigger, and remaps reads
// so logical address 0 is the oldest sample of the capture.
//   clk, analyzer_rstn_sync : clock, async active-low reset
//   digital_in, trig        : sampled channels and combined trigger
//   arm, abort              : start (latches config) / stop pulses
//   pretrig_len, sample_div : pre-trigger count and sample period minus 1
//   rd_en, rd_addr          : logical read request (0 = oldest)
//   rd_data, rd_valid       : read data, one cycle after rd_en
//   busy, done, triggered, trig_pos : capture status
module analyzer_capture_buffer
    import analyzer_pkg::*;
#(
    parameter int CH_NUM = 8,
    parameter int ADDR_W = 12,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              analyzer_rstn_sync,
    input  logic [CH_NUM-1:0] digital_in,
    input  logic              trig,
    input  logic              arm,
    input  logic              abort,
    input  logic [ADDR_W-1:0] pretrig_len,
    input  logic [DIV_W-1:0]  sample_div,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CH_NUM-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              triggered,
    output logic [ADDR_W-1:0] trig_pos
);

    localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [DIV_W-1:0]  D_ONE     = DIV_W'(1);

    capture_state_t    state_q;
    logic [CH_NUM-1:0] din_q;
    logic              trig_q;
    logic [DIV_W-1:0]  div_l_q;
    logic [DIV_W-1:0]  div_cnt_q;
    logic [ADDR_W-1:0] pre_l_q;
    logic [ADDR_W-1:0] pre_cnt_q;
    logic [ADDR_W-1:0] post_left_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] trig_ptr_q;
    logic              trig_pend_q;
    logic              triggered_q;
    logic              rd_valid_q;

    logic              busy_w;
    logic              strobe;
    logic              wr_en;
    logic [ADDR_W-1:0] post_init;
    logic [ADDR_W-1:0] start_ptr;
    logic [ADDR_W-1:0] rd_phys;

    assign busy_w    = is_busy(state_q);
    assign strobe    = busy_w && (div_cnt_q == div_l_q);
    // A restart or abort discards the sample that would land on that edge.
    assign wr_en     = strobe && !arm && !abort;
    assign post_init = LAST_ADDR - pre_l_q;
    assign start_ptr = trig_ptr_q - pre_l_q;
    assign rd_phys   = start_ptr + rd_addr;

    // Input stage: data and trigger share one flop stage so they stay aligned.
    always_ff @(posedge clk or negedge analyzer_rstn_sync) begin
        if (!analyzer_rstn_sync) begin
            din_q      <= '0;
            trig_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            din_q      <= digital_in;
            trig_q     <= trig;
            rd_valid_q <= rd_en;
        end
    end

    // Capture FSM, divider and pointers.
    always_ff @(posedge clk or negedge analyzer_rstn_sync) begin
        if (!analyzer_rstn_sync) begin
            state_q     <= ST_IDLE;
            div_l_q     <= '0;
            div_cnt_q   <= '0;
            pre_l_q     <= '0;
            pre_cnt_q   <= '0;
            post_left_q <= '0;
            wr_ptr_q    <= '0;
            trig_ptr_q  <= '0;
            trig_pend_q <= 1'b0;
            triggered_q <= 1'b0;
        end else if (abort) begin
            // triggered/trig_ptr/pre_l are kept so trig_pos survives an abort.
            state_q     <= ST_IDLE;
            trig_pend_q <= 1'b0;
        end else if (arm) begin
            // pretrig_len is ADDR_W wide, so it can never exceed DEPTH-1.
            state_q     <= (pretrig_len == '0) ? ST_WAIT : ST_PRE;
            div_l_q     <= sample_div;
            pre_l_q     <= pretrig_len;
            div_cnt_q   <= '0;
            pre_cnt_q   <= '0;
            post_left_q <= '0;
            wr_ptr_q    <= '0;
            trig_pend_q <= 1'b0;
            triggered_q <= 1'b0;
        end else if (busy_w) begin
            div_cnt_q <= strobe ? '0 : div_cnt_q + D_ONE;
            if (strobe) begin
                wr_ptr_q <= wr_ptr_q + A_ONE;
            end
            case (state_q)
                ST_PRE: begin
                    if (strobe) begin
                        pre_cnt_q <= pre_cnt_q + A_ONE;
                        if (pre_cnt_q + A_ONE == pre_l_q) begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (strobe && (trig_q || trig_pend_q)) begin
                        trig_ptr_q  <= wr_ptr_q;
                        triggered_q <= 1'b1;
                        trig_pend_q <= 1'b0;
                        post_left_q <= post_init;
                        state_q     <= (post_init == '0) ? ST_DONE : ST_POST;
                    end else if (trig_q) begin
                        // Remember a short trigger pulse until the next strobe.
                        trig_pend_q <= 1'b1;
                    end
                end
                ST_POST: begin
                    if (strobe) begin
                        post_left_q <= post_left_q - A_ONE;
                        if (post_left_q == A_ONE) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    analyzer_wave_ram #(
        .DATA_W (CH_NUM),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk                (clk),
        .analyzer_rstn_sync (analyzer_rstn_sync),
        .wr_en_i            (wr_en),
        .wr_addr_i          (wr_ptr_q),
        .wr_data_i          (din_q),
        .rd_en_i            (rd_en),
        .rd_addr_i          (rd_phys),
        .rd_data_o          (rd_data)
    );

    assign rd_valid  = rd_valid_q;
    assign busy      = busy_w;
    assign done      = (state_q == ST_DONE);
    assign triggered = triggered_q;
    assign trig_pos  = triggered_q ? pre_l_q : '0;

endmodule
